// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the counter / timer family.
//   MODE_WRAP, MODE_SAT : values for a counter's SATURATE parameter
//   clamp_to_max()      : limits a value to an inclusive upper bound
package counter_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Widened to 32 bits so every counter width up to 32 can share it.
   function automatic logic [31:0] clamp_to_max(input logic [31:0] val,
                                                input logic [31:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control and status bundle of updown_mod_counter.
//   master : drives en, up, clear, load, load_val; observes the status signals
//   slave  : the counter; drives q, tc, wrap, at_max, at_zero
interface updown_mod_counter_if #(
   parameter int unsigned WIDTH = 4
);

   logic             en;
   logic             up;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             at_max;
   logic             at_zero;

   modport master (
      output en, up, clear, load, load_val,
      input  q, tc, wrap, at_max, at_zero
   );

   modport slave (
      input  en, up, clear, load, load_val,
      output q, tc, wrap, at_max, at_zero
   );

endinterface

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo up/down counter with count enable, synchronous
// clear, clamped parallel load, wrap or saturate at the range ends, and
// terminal-count output for cascading.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, q -> RESET_VAL, wrap -> 0
//   bus    : slave side of updown_mod_counter_if
//            in : en, up, clear, load, load_val
//            out: q (reg), wrap (reg pulse), tc / at_max / at_zero (comb)
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter logic [31:0] MAX_VAL   = 32'((64'd1 << WIDTH) - 64'd1),
   parameter int          SATURATE  = MODE_WRAP,
   parameter logic [31:0] RESET_VAL = 32'd0
) (
   input  logic                clk,
   input  logic                reset,
   updown_mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_Q = MAX_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_r;
   logic             wrap_nxt;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (q_r == MAX_Q);
   assign at_zero = (q_r == '0);

   // Range ends are detected before stepping, so a MAX_VAL below
   // 2**WIDTH-1 never relies on natural overflow.
   always_comb begin
      q_nxt    = q_r;
      wrap_nxt = 1'b0;
      if (bus.clear) begin
         q_nxt = RST_Q;
      end else if (bus.load) begin
         q_nxt = WIDTH'(clamp_to_max(32'(bus.load_val), MAX_VAL));
      end else if (bus.en) begin
         if (bus.up) begin
            if (!at_max) begin
               q_nxt = q_r + WIDTH'(1);
            end else if (SATURATE == MODE_WRAP) begin
               q_nxt    = '0;
               wrap_nxt = 1'b1;
            end
         end else begin
            if (!at_zero) begin
               q_nxt = q_r - WIDTH'(1);
            end else if (SATURATE == MODE_WRAP) begin
               q_nxt    = MAX_Q;
               wrap_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_r    <= RST_Q;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
      end
   end

   assign bus.q       = q_r;
   assign bus.wrap    = wrap_r;
   assign bus.at_max  = at_max;
   assign bus.at_zero = at_zero;
   // Asserted in saturate mode too: it marks the edge a cascaded stage steps on.
   assign bus.tc      = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's fixed 4-bit synchronous up counter.
- Adds configurable width and modulus, up/down direction, count enable, synchronous clear and parallel load.
- Supports wrap or saturate mode, and provides terminal-count and wrap-event outputs.
- Used as a general event/timebase counter and cascadable (via tc) for multi-digit (e.g. BCD) chains.

Parameters:
- WIDTH, 4, bit width of count register q (1..32)
- MAX_VAL, 2**WIDTH-1, highest legal count; count range is 0..MAX_VAL; must be < 2**WIDTH
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends
- RESET_VAL, 0, value of q on reset and clear; must be <= MAX_VAL

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately, independent of clk
- en  in  1  count enable; q steps only when en=1
- up  in  1  direction: 1 = increment, 0 = decrement
- clear  in  1  synchronous clear to RESET_VAL
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value loaded when load=1
- q  out  WIDTH  current count (registered)
- tc  out  1  terminal count (combinational from q, en, up)
- wrap  out  1  registered one-cycle pulse marking a wrap event
- at_max  out  1  q == MAX_VAL (combinational)
- at_zero  out  1  q == 0 (combinational)

Behaviour:
- Reset (async, any time, including mid-count or mid-load): q = RESET_VAL and wrap = 0 immediately. tc, at_max and at_zero follow q.
- Priority at each rising clk edge with reset=0: clear > load > en > hold.
- clear=1: q <= RESET_VAL, wrap <= 0. Overrides load and en in the same cycle.
- load=1 (clear=0): q <= min(load_val, MAX_VAL); out-of-range loads clamp to MAX_VAL. wrap <= 0. en is ignored that cycle.
- en=1, up=1:
  - q < MAX_VAL: q <= q+1.
  - q == MAX_VAL, SATURATE=0: q <= 0, wrap <= 1.
  - q == MAX_VAL, SATURATE=1: q holds, wrap <= 0.
- en=1, up=0:
  - q > 0: q <= q-1.
  - q == 0, SATURATE=0: q <= MAX_VAL, wrap <= 1.
  - q == 0, SATURATE=1: q holds, wrap <= 0.
- en=0 (no clear/load): q holds, wrap <= 0.
- wrap is high for exactly the one cycle following the wrapping edge, i.e. it is coincident with the new q value.
- tc = en & ((up & q==MAX_VAL) | (~up & q==0)).
  - Asserted in both modes; it identifies the edge on which a cascaded next stage should step (connect to that stage's en).
- Arithmetic is internal to WIDTH bits. Compare against MAX_VAL before stepping; never rely on natural 2**WIDTH overflow unless MAX_VAL = 2**WIDTH-1.
- Direction may change on any cycle; the new direction applies on that edge with no latency.
- Count latency: one clk edge from en to new q. No pipelining.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants MODE_WRAP=0 and MODE_SAT=1
  - a function clamp_to_max(val, max) reused by future timer/prescaler blocks
- Single module; no sub-module is natural. The next-state logic is one priority-encoded always block plus the combinational flag assigns.

Test Plan:
- Reset mid-count: WIDTH=4, MAX_VAL=9, count to q=5, assert reset between edges -> q=0 immediately, before the next posedge; wrap=0.
- Decade wrap up: MAX_VAL=9, en=1, up=1 from 0 for 10 edges -> q steps 0..9. tc=1 while q=9. The next edge gives q=0 with wrap=1 for one cycle only.
- Down wrap: MAX_VAL=9, load 2, up=0, en=1 for 3 edges -> q = 1, 0, 9. wrap=1 in the cycle q=9. tc=1 in the cycle q=0.
- Saturate: SATURATE=1, MAX_VAL=12, WIDTH=4, load 11, up=1, en=1 for 4 edges -> q = 12, 12, 12, 12; wrap never asserts; tc=1 while q=12.
- Priority and clamp: WIDTH=4, MAX_VAL=9:
  - clear=1, load=1, load_val=7, en=1 on the same edge -> q=RESET_VAL=0.
  - Next edge with load=1, load_val=14 -> q=9 (clamped); en ignored.
- Cascade: two instances (MAX_VAL=9), the second instance's en driven by the first instance's tc, 100 up-counts from reset -> tens = 0 and units = 0. Both wrap pulses fire together on the 100th edge.
